// File: rtl/plot_arbiter.sv
// Round-robin arbiter for the vga_core pixel-write port, with a built-in
// clear-screen sweep that preempts all requesters.
module plot_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear_req,
    input  logic [2:0]           clear_color,
    output logic                 clear_busy,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*3-1:0] req_color,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           color,
    output logic                 plot,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic [7:0]     sel_x;
    logic [6:0]     sel_y;
    logic [2:0]     sel_color;
    logic [7:0]     cx;
    logic [6:0]     cy;
    logic [2:0]     clr_color;
    logic           transfer;
    logic           in_range;
    logic           sweep_last;

    // Rotating priority search: iterate downward so the lowest offset from ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr) + k) % NUM_REQ);
            end
        end
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_x     = req_x[8*i +: 8];
                sel_y     = req_y[7*i +: 7];
                sel_color = req_color[3*i +: 3];
            end
        end
    end

    assign transfer   = |(req_valid & req_ready);
    assign in_range   = (sel_x < 8'(H_RES)) && (sel_y < 7'(V_RES));
    assign sweep_last = (cx == 8'(H_RES - 1)) && (cy == 7'(V_RES - 1));
    assign clear_busy = (state == CLEAR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req)  state_nxt = CLEAR;
            CLEAR:   if (sweep_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (resetn && state == IDLE && !clear_req && gnt_found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx == IDW'(i)) req_ready[i] = 1'b1;
            end
        end
    end

    // Output register stage: one cycle from transfer or sweep step to plot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x         <= '0;
            y         <= '0;
            color     <= '0;
            plot      <= 1'b0;
            grant_id  <= '0;
            ptr       <= '0;
            cx        <= '0;
            cy        <= '0;
            clr_color <= '0;
        end else if (state == IDLE) begin
            if (clear_req) begin
                clr_color <= clear_color;
                cx        <= '0;
                cy        <= '0;
                plot      <= 1'b0;
            end else begin
                plot <= transfer && in_range;
                if (transfer) begin
                    ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    // Off-screen pixels are consumed but leave the outputs untouched.
                    if (in_range) begin
                        x        <= sel_x;
                        y        <= sel_y;
                        color    <= sel_color;
                        grant_id <= gnt_idx;
                    end
                end
            end
        end else begin
            x     <= cx;
            y     <= cy;
            color <= clr_color;
            plot  <= 1'b1;
            if (cx == 8'(H_RES - 1)) begin
                cx <= '0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule
